// File: rtl/mor1kx_spr_dbg_pkg.sv
// Shared types and constants for the debug-port SPR bus initiator.
package mor1kx_spr_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        ACCESS = 3'd2,
        RDATA  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // GPR window served by the register file; SPR group number sits above bit 11.
    localparam logic [15:0] SPR_GPR_BASE    = 16'h0400;
    localparam int          SPR_GROUP_SHIFT = 11;

    function automatic int timer_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/mor1kx_spr_dbg_initiator_if.sv
// Debug-port and SPR-bus signal bundle for the SPR debug initiator.
interface mor1kx_spr_dbg_initiator_if #(
    parameter int OPERAND_WIDTH = 32,
    parameter int BURST_WIDTH   = 5
);
    // Every valid/ready pair transfers exactly on a rising edge where both are
    // high; the producer holds payload stable while valid is high and ready low.
    logic                     dbg_req_valid_i;
    logic                     dbg_req_ready_o;
    logic                     dbg_req_we_i;
    logic [15:0]              dbg_req_addr_i;
    logic [BURST_WIDTH-1:0]   dbg_req_len_i;
    logic                     dbg_wdat_valid_i;
    logic                     dbg_wdat_ready_o;
    logic [OPERAND_WIDTH-1:0] dbg_wdat_i;
    logic                     dbg_rdat_valid_o;
    logic                     dbg_rdat_ready_i;
    logic [OPERAND_WIDTH-1:0] dbg_rdat_o;
    logic                     dbg_done_o;
    logic                     dbg_err_o;
    logic [15:0]              spr_bus_addr_o;
    logic                     spr_bus_stb_o;
    logic                     spr_bus_we_o;
    logic [OPERAND_WIDTH-1:0] spr_bus_dat_o;
    logic                     spr_bus_ack_i;
    logic [OPERAND_WIDTH-1:0] spr_bus_dat_i;

    modport master (
        input  dbg_req_valid_i, dbg_req_we_i, dbg_req_addr_i, dbg_req_len_i,
               dbg_wdat_valid_i, dbg_wdat_i, dbg_rdat_ready_i,
               spr_bus_ack_i, spr_bus_dat_i,
        output dbg_req_ready_o, dbg_wdat_ready_o, dbg_rdat_valid_o, dbg_rdat_o,
               dbg_done_o, dbg_err_o,
               spr_bus_addr_o, spr_bus_stb_o, spr_bus_we_o, spr_bus_dat_o
    );

    modport slave (
        output dbg_req_valid_i, dbg_req_we_i, dbg_req_addr_i, dbg_req_len_i,
               dbg_wdat_valid_i, dbg_wdat_i, dbg_rdat_ready_i,
               spr_bus_ack_i, spr_bus_dat_i,
        input  dbg_req_ready_o, dbg_wdat_ready_o, dbg_rdat_valid_o, dbg_rdat_o,
               dbg_done_o, dbg_err_o,
               spr_bus_addr_o, spr_bus_stb_o, spr_bus_we_o, spr_bus_dat_o
    );

endinterface

// File: rtl/mor1kx_spr_dbg_initiator.sv
// Debug-port to SPR-bus initiator: turns single/burst debug requests into strobed
// SPR accesses, aborting on a strobe timeout so a silent responder cannot wedge the link.
module mor1kx_spr_dbg_initiator
    import mor1kx_spr_dbg_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH  = 32,
    parameter int OPTION_BURST_WIDTH    = 5,
    parameter int OPTION_TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    mor1kx_spr_dbg_initiator_if.master  bus,
    output state_t                      state_dbg
);

    localparam int TIMER_WIDTH = timer_width(OPTION_TIMEOUT_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(OPTION_TIMEOUT_CYCLES - 1);

    state_t                          state;
    state_t                          state_next;
    logic [15:0]                     base_q;
    logic                            we_q;
    logic [OPTION_BURST_WIDTH-1:0]   len_q;
    logic [OPTION_BURST_WIDTH-1:0]   cnt_q;
    logic [TIMER_WIDTH-1:0]          timer_q;
    logic [OPTION_OPERAND_WIDTH-1:0] wdat_q;
    logic [OPTION_OPERAND_WIDTH-1:0] rdat_q;
    logic                            err_q;

    logic last_word;
    logic acked;
    logic timed_out;

    // Ack only counts while strobing; an ack on the final timer cycle still wins.
    assign last_word = (cnt_q == len_q);
    assign acked     = (state == ACCESS) && bus.spr_bus_ack_i;
    assign timed_out = (state == ACCESS) && !bus.spr_bus_ack_i && (timer_q == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.dbg_req_valid_i) begin
                    state_next = bus.dbg_req_we_i ? WDATA : ACCESS;
                end
            end
            WDATA: begin
                if (bus.dbg_wdat_valid_i) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (acked) begin
                    if (!we_q) begin
                        state_next = RDATA;
                    end else begin
                        state_next = last_word ? DONE : WDATA;
                    end
                end else if (timed_out) begin
                    state_next = DONE;
                end
            end
            RDATA: begin
                if (bus.dbg_rdat_ready_i) begin
                    state_next = last_word ? DONE : ACCESS;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Timer restarts whenever ACCESS is (re)entered, since it is held at zero elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            we_q    <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= (state == ACCESS) ? timer_q + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (bus.dbg_req_valid_i) begin
                        base_q <= bus.dbg_req_addr_i;
                        we_q   <= bus.dbg_req_we_i;
                        len_q  <= bus.dbg_req_len_i;
                        cnt_q  <= '0;
                    end
                end
                WDATA: begin
                    if (bus.dbg_wdat_valid_i) begin
                        wdat_q <= bus.dbg_wdat_i;
                    end
                end
                ACCESS: begin
                    if (acked) begin
                        if (!we_q) begin
                            rdat_q <= bus.spr_bus_dat_i;
                        end else if (!last_word) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end
                end
                RDATA: begin
                    if (bus.dbg_rdat_ready_i && !last_word) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Outputs are forced low while rst is high so a mid-access reset drops stb at once.
    always_comb begin
        bus.dbg_req_ready_o  = 1'b0;
        bus.dbg_wdat_ready_o = 1'b0;
        bus.dbg_rdat_valid_o = 1'b0;
        bus.dbg_rdat_o       = '0;
        bus.dbg_done_o       = 1'b0;
        bus.dbg_err_o        = 1'b0;
        bus.spr_bus_addr_o   = '0;
        bus.spr_bus_stb_o    = 1'b0;
        bus.spr_bus_we_o     = 1'b0;
        bus.spr_bus_dat_o    = '0;
        state_dbg            = IDLE;
        if (!rst) begin
            state_dbg = state;
            case (state)
                IDLE:  bus.dbg_req_ready_o  = 1'b1;
                WDATA: bus.dbg_wdat_ready_o = 1'b1;
                ACCESS: begin
                    bus.spr_bus_stb_o  = 1'b1;
                    bus.spr_bus_addr_o = base_q + 16'(cnt_q);
                    bus.spr_bus_we_o   = we_q;
                    bus.spr_bus_dat_o  = we_q ? wdat_q : '0;
                end
                RDATA: begin
                    bus.dbg_rdat_valid_o = 1'b1;
                    bus.dbg_rdat_o       = rdat_q;
                end
                DONE: begin
                    bus.dbg_done_o = 1'b1;
                    bus.dbg_err_o  = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mor1kx_spr_dbg_initiator.sv
// Self-checking bench for mor1kx_spr_dbg_initiator: random debug requests against a
// transaction-level model, with a responder and a scoreboard monitor on the DUT outputs.
module tb_mor1kx_spr_dbg_initiator;
    import mor1kx_spr_dbg_pkg::*;

    localparam int OW  = 32;
    localparam int BW  = 5;
    localparam int TMO = 8;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t state_dbg;

    always #5 clk = ~clk;

    mor1kx_spr_dbg_initiator_if #(.OPERAND_WIDTH(OW), .BURST_WIDTH(BW)) bus();

    mor1kx_spr_dbg_initiator #(
        .OPTION_OPERAND_WIDTH (OW),
        .OPTION_BURST_WIDTH   (BW),
        .OPTION_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [15:0]   addr;
        logic          we;
        logic [OW-1:0] dat;
    } acc_t;

    typedef struct {
        logic err;
        int   run;
    } done_t;

    acc_t          exp_acc_q[$];
    logic [OW-1:0] exp_q[$];
    done_t         exp_done_q[$];
    logic [OW-1:0] wr_words[$];
    logic [OW-1:0] ref_mem[logic [15:0]];
    logic [OW-1:0] resp_mem[logic [15:0]];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: actual=0x%0h expected=none", name, act);
    endtask

    function automatic logic [OW-1:0] dflt_val(input logic [15:0] a);
        return {~a, a};
    endfunction

    function automatic logic [OW-1:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt_val(a);
    endfunction

    function automatic logic [OW-1:0] resp_rd(input logic [15:0] a);
        if (resp_mem.exists(a)) return resp_mem[a];
        return dflt_val(a);
    endfunction

    // ---------------- SPR responder ----------------
    int resp_wait   = 0;
    bit spurious_en = 1'b0;
    int stb_seen    = 0;

    always @(posedge clk) begin
        #1;
        if (bus.spr_bus_stb_o) begin
            stb_seen++;
            if (stb_seen > resp_wait) begin
                bus.spr_bus_ack_i = 1'b1;
                if (bus.spr_bus_we_o) begin
                    resp_mem[bus.spr_bus_addr_o] = bus.spr_bus_dat_o;
                    bus.spr_bus_dat_i = $urandom;
                end else begin
                    bus.spr_bus_dat_i = resp_rd(bus.spr_bus_addr_o);
                end
            end else begin
                bus.spr_bus_ack_i = 1'b0;
                bus.spr_bus_dat_i = $urandom;
            end
        end else begin
            stb_seen          = 0;
            bus.spr_bus_ack_i = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.spr_bus_dat_i = $urandom;
        end
    end

    // ---------------- monitor ----------------
    int    run_len  = 0;
    int    last_run = 0;
    acc_t  mon_acc;
    done_t mon_done;

    always @(negedge clk) begin
        if (bus.spr_bus_stb_o) begin
            run_len++;
        end else begin
            if (run_len > 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            chk("idle_bus_we", 64'(bus.spr_bus_we_o), 64'd0);
            chk("idle_bus_dat", 64'(bus.spr_bus_dat_o), 64'd0);
        end
        if (bus.spr_bus_stb_o && bus.spr_bus_ack_i) begin
            if (exp_acc_q.size() == 0) begin
                fail_now("unexpected_access", 64'(bus.spr_bus_addr_o));
            end else begin
                mon_acc = exp_acc_q.pop_front();
                chk("acc_addr", 64'(bus.spr_bus_addr_o), 64'(mon_acc.addr));
                chk("acc_we", 64'(bus.spr_bus_we_o), 64'(mon_acc.we));
                if (mon_acc.we) chk("acc_wdat", 64'(bus.spr_bus_dat_o), 64'(mon_acc.dat));
            end
        end
        if (bus.dbg_rdat_valid_o) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_rdat", 64'(bus.dbg_rdat_o));
            end else begin
                chk("rdat", 64'(bus.dbg_rdat_o), 64'(exp_q[0]));
                if (bus.dbg_rdat_ready_i) void'(exp_q.pop_front());
            end
        end
        if (bus.dbg_done_o) begin
            if (exp_done_q.size() == 0) begin
                fail_now("unexpected_done", 64'(bus.dbg_err_o));
            end else begin
                mon_done = exp_done_q.pop_front();
                chk("done_err", 64'(bus.dbg_err_o), 64'(mon_done.err));
                chk("done_stb_cycles", 64'(last_run), 64'(mon_done.run));
            end
        end else if (bus.dbg_err_o) begin
            fail_now("err_without_done", 64'(bus.dbg_err_o));
        end
    end

    // ---------------- driver ----------------
    // rdy_mode: 0 = always ready/valid, 1 = random handshakes, 2 = stall each read word 5 cycles
    task automatic run_req(input bit we, input logic [15:0] addr, input int len,
                           input int wait_cyc, input int rdy_mode, output int lat);
        int widx;
        int stall_left;
        int n;
        logic [15:0] a;
        if (we) while (wr_words.size() < len + 1) wr_words.push_back($urandom);
        if (wait_cyc >= TMO) begin
            exp_done_q.push_back('{1'b1, TMO});
        end else begin
            for (int i = 0; i <= len; i++) begin
                a = addr + 16'(i);
                if (we) begin
                    exp_acc_q.push_back('{a, 1'b1, wr_words[i]});
                    ref_mem[a] = wr_words[i];
                end else begin
                    exp_acc_q.push_back('{a, 1'b0, '0});
                    exp_q.push_back(ref_rd(a));
                end
            end
            exp_done_q.push_back('{1'b0, wait_cyc + 1});
        end
        resp_wait = wait_cyc;

        @(posedge clk); #1;
        bus.dbg_req_valid_i = 1'b1;
        bus.dbg_req_we_i    = we;
        bus.dbg_req_addr_i  = addr;
        bus.dbg_req_len_i   = BW'(len);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dbg_req_ready_o && n < 20);
        if (!bus.dbg_req_ready_o) fail_now("req_handshake_timeout", 64'(n));

        widx       = 0;
        stall_left = (rdy_mode == 2) ? 5 : 0;
        lat        = 0;
        forever begin
            @(posedge clk); #1;
            bus.dbg_req_valid_i  = 1'b0;
            bus.dbg_req_addr_i   = 16'($urandom);
            bus.dbg_wdat_valid_i = we && (widx <= len) && (rdy_mode != 1 || $urandom_range(0, 1) == 1);
            bus.dbg_wdat_i       = (widx <= len && we) ? wr_words[widx] : OW'($urandom);
            case (rdy_mode)
                0:       bus.dbg_rdat_ready_i = 1'b1;
                1:       bus.dbg_rdat_ready_i = 1'($urandom_range(0, 1));
                default: bus.dbg_rdat_ready_i = (stall_left == 0);
            endcase
            @(negedge clk);
            lat++;
            if (bus.dbg_wdat_valid_i && bus.dbg_wdat_ready_o) widx++;
            if (rdy_mode == 2 && bus.dbg_rdat_valid_o) begin
                if (bus.dbg_rdat_ready_i) stall_left = 5;
                else stall_left--;
            end
            if (bus.dbg_req_ready_o) break;
            if (lat > 200) begin
                fail_now("req_complete_timeout", 64'(lat));
                break;
            end
        end
        bus.dbg_wdat_valid_i = 1'b0;
        wr_words.delete();
    endtask

    // ---------------- main sequence ----------------
    int lat;
    int n;

    initial begin
        bus.dbg_req_valid_i  = 1'b0;
        bus.dbg_req_we_i     = 1'b0;
        bus.dbg_req_addr_i   = '0;
        bus.dbg_req_len_i    = '0;
        bus.dbg_wdat_valid_i = 1'b0;
        bus.dbg_wdat_i       = '0;
        bus.dbg_rdat_ready_i = 1'b0;
        bus.spr_bus_ack_i    = 1'b0;
        bus.spr_bus_dat_i    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(bus.dbg_req_ready_o), 64'd0);
        chk("reset_stb", 64'(bus.spr_bus_stb_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", 64'(bus.dbg_req_ready_o), 64'd1);
        chk("post_reset_done", 64'(bus.dbg_done_o), 64'd0);
        chk("post_reset_rdat_valid", 64'(bus.dbg_rdat_valid_o), 64'd0);
        chk("post_reset_state", 64'(state_dbg), 64'(IDLE));

        // single zero-wait read
        ref_mem[16'h0403]  = 32'hDEADBEEF;
        resp_mem[16'h0403] = 32'hDEADBEEF;
        run_req(1'b0, 16'h0403, 0, 0, 0, lat);
        chk("single_read_latency", 64'(lat), 64'd4);

        // single zero-wait write
        run_req(1'b1, 16'h0500, 0, 0, 0, lat);
        chk("single_write_latency", 64'(lat), 64'd4);

        // write burst with two wait states, then read it back
        wr_words = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_req(1'b1, SPR_GPR_BASE, 3, 2, 0, lat);
        run_req(1'b0, SPR_GPR_BASE, 3, 1, 1, lat);

        // timeouts, and an ack landing in the last allowed strobe cycle
        run_req(1'b0, 16'h0800, 0, 1000, 0, lat);
        run_req(1'b1, 16'h0801, 2, 1000, 0, lat);
        run_req(1'b0, 16'h0C00, 0, TMO - 1, 0, lat);
        run_req(1'b1, 16'h0C01, 1, TMO - 1, 0, lat);

        // address wrap with stalled read data
        run_req(1'b0, 16'hFFFF, 1, 0, 2, lat);

        // reset during the third strobe cycle of a waited read
        resp_wait = 100;
        @(posedge clk); #1;
        bus.dbg_req_valid_i = 1'b1;
        bus.dbg_req_we_i    = 1'b0;
        bus.dbg_req_addr_i  = 16'h0410;
        bus.dbg_req_len_i   = '0;
        @(negedge clk);
        chk("rst_test_req_ready", 64'(bus.dbg_req_ready_o), 64'd1);
        @(posedge clk); #1;
        bus.dbg_req_valid_i = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (bus.spr_bus_stb_o) n++;
        end
        chk("rst_test_stb_cycles", 64'(n), 64'd2);
        @(posedge clk); #1;
        chk("rst_test_third_stb", 64'(bus.spr_bus_stb_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_drops_stb", 64'(bus.spr_bus_stb_o), 64'd0);
        @(negedge clk);
        chk("rst_held_stb", 64'(bus.spr_bus_stb_o), 64'd0);
        chk("rst_held_req_ready", 64'(bus.dbg_req_ready_o), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_req_ready", 64'(bus.dbg_req_ready_o), 64'd1);
        chk("rst_release_state", 64'(state_dbg), 64'(IDLE));

        // spurious acks while idle must not disturb anything
        spurious_en = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("spurious_idle_state", 64'(state_dbg), 64'(IDLE));
            chk("spurious_idle_ready", 64'(bus.dbg_req_ready_o), 64'd1);
        end

        // randomized mix with spurious acks and random handshakes
        for (int t = 0; t < 24; t++) begin
            bit          r_we;
            logic [15:0] r_addr;
            int          r_len;
            int          r_wait;
            r_we   = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 1) == 1)
                   ? SPR_GPR_BASE + 16'($urandom_range(0, 15))
                   : 16'($urandom_range(0, 3) << SPR_GROUP_SHIFT) + 16'($urandom_range(0, 15));
            r_len  = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0:       r_wait = TMO + 2;
                1:       r_wait = TMO - 1;
                default: r_wait = $urandom_range(0, 3);
            endcase
            run_req(r_we, r_addr, r_len, r_wait, 1, lat);
        end

        spurious_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("leftover_accesses", 64'(exp_acc_q.size()), 64'd0);
        chk("leftover_rdat", 64'(exp_q.size()), 64'd0);
        chk("leftover_done", 64'(exp_done_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mor1kx_spr_dbg_initiator.md
# mor1kx_spr_dbg_initiator

Bus-master side of the SPR bus: converts debug-port requests (single or burst, read or write) into SPR bus transactions and waits for the responder's ack. The main targets are the GPR window (0x0400 onward) served by the register file, and any other SPR group. It sits between the external debug interface and the CPU's SPR bus mux, with a timeout so that a missing responder cannot hang the debug link.

## Interface
- OPTION_OPERAND_WIDTH, 32, SPR data width
- OPTION_BURST_WIDTH, 5, width of burst length field (max 2^W words)
- OPTION_TIMEOUT_CYCLES, 255, strobe cycles without ack before abort (≥1)

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dbg_req_valid_i  in  1  request offered
- dbg_req_ready_o  out  1  request accepted when high with valid
- dbg_req_we_i  in  1  1 = write burst
- dbg_req_addr_i  in  16  first SPR address
- dbg_req_len_i  in  OPTION_BURST_WIDTH  words minus one
- dbg_wdat_valid_i / dbg_wdat_ready_o  in / out  1  write-data handshake
- dbg_wdat_i  in  OPERAND_WIDTH  write word
- dbg_rdat_valid_o / dbg_rdat_ready_i  out / in  1  read-data handshake
- dbg_rdat_o  out  OPERAND_WIDTH  read word
- dbg_done_o  out  1  one-cycle end-of-request pulse
- dbg_err_o  out  1  valid with done; 1 = timeout abort
- spr_bus_addr_o  out  16  SPR address
- spr_bus_stb_o  out  1  access strobe
- spr_bus_we_o  out  1  write enable
- spr_bus_dat_o  out  OPERAND_WIDTH  write data
- spr_bus_ack_i  in  1  responder ack
- spr_bus_dat_i  in  OPERAND_WIDTH  responder read data

## Operation
- States: IDLE, WDATA, ACCESS, RDATA, DONE.
- IDLE: req_ready=1. On valid&ready, latch addr, we, len; cnt=0. Go to WDATA if we, else ACCESS.
- WDATA: wdat_ready=1. On wdat_valid, latch word into spr_bus_dat_o. Go to ACCESS.
- ACCESS: stb=1, addr=base+cnt (16-bit wrap, 0xFFFF+1=0x0000), we=latched we. Timer counts strobe cycles.
  - On ack, read: capture spr_bus_dat_i and go to RDATA.
  - On ack, write: if cnt==len go to DONE; else cnt++ and go to WDATA.
  - If the timer reaches OPTION_TIMEOUT_CYCLES without ack: set err and go to DONE. Remaining words are abandoned and no wdat/rdat handshakes follow.
- RDATA: rdat_valid=1, holding the word stable until ready. On ready: if cnt==len go to DONE; else cnt++ and go to ACCESS.
- DONE: done=1 and err as latched, for one cycle. Then go to IDLE and clear err.
- Ack is sampled only while stb=1; ack with stb=0 is ignored.
- Ack in the first stb cycle (zero-wait responder) is legal.
- Ack in the final timeout cycle counts as success.
- Timer clears on every entry to ACCESS.
- spr_bus_we_o and spr_bus_dat_o are driven only while stb=1, else 0.
- Reset (any state, including mid-access) forces IDLE, drops stb the same cycle rst is sampled, and clears cnt, timer and err.
- All outputs are 0 during and after reset except dbg_req_ready_o, which is 1 from the first cycle after rst deasserts.

## Timing
- Single read, zero-wait ack:
  - c0: request handshake.
  - c1: stb, ack.
  - c2: rdat_valid (ready=1).
  - c3: done.
  - c4: req_ready.
- Single write: request at c0, wdat handshake at c1, stb at c2, done at c3 with zero-wait ack.
- Back-to-back strobes never occur: at least one non-stb cycle separates accesses (WDATA or RDATA in between).
- A timeout gives exactly OPTION_TIMEOUT_CYCLES stb cycles, then done+err on the next cycle.
- Responses complete in request order; no overlap, at most one request in flight.

## Structure
- Shared package mor1kx_spr_dbg_pkg:
  - state enum;
  - SPR group constants (SPR_GPR_BASE = 16'h0400, group shift 11);
  - timer width function clog2(OPTION_TIMEOUT_CYCLES+1).
- Single flat module; the timer and counter are inline. No sub-module.

## Test plan
- Read 1 word at 0x0403, responder acks in 1st cycle with 0xDEADBEEF: expect rdat 0xDEADBEEF, done=1, err=0, 4 cycles request→ready again.
- Write burst, len=3, base 0x0400, data 1..4, responder ack after 2 wait cycles: expect stb addresses 0x0400..0x0403 with we=1 and matching data, then a single done, err=0.
- No ack, OPTION_TIMEOUT_CYCLES=8: expect exactly 8 stb cycles, then done+err=1, no rdat_valid.
  - Rerun with ack in the 8th cycle: expect success.
- Read burst len=1 from base 0xFFFF with rdat_ready low for 5 cycles: expect addresses 0xFFFF then 0x0000, rdat held stable while stalled.
- Assert rst during the 3rd stb cycle of a waited access: expect stb=0 the same cycle rst is sampled, no done, and req_ready=1 the cycle after rst deasserts.
- Spurious ack pulses while IDLE/WDATA: expect no state change and no captured data.
